// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
package dm_pkg;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_BU = 3'b001;
    localparam logic [2:0] OP_B  = 3'b010;
    localparam logic [2:0] OP_HU = 3'b011;
    localparam logic [2:0] OP_H  = 3'b100;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dm_access_ctrl_load_extend.sv
// Byte/half lane select and sign/zero extension of a read word.
module load_extend
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = word[{addr_lo, 3'b000} +: 8];
        half_val = addr_lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_BU:   ext = {24'd0, byte_val};
            OP_B:    ext = {{24{byte_val[7]}}, byte_val};
            OP_HU:   ext = {16'd0, half_val};
            OP_H:    ext = {{16{half_val[15]}}, half_val};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: alignment check, bus req/ack handshake,
// pipeline stall and load-data extension.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               flushed;
    logic [2:0]         lat_op;
    logic [1:0]         lat_lo;
    logic               misaligned;
    logic [3:0]         be_next;
    logic [31:0]        wdata_next;
    logic [31:0]        ext_data;
    logic               req_go;
    logic               accept;
    logic               kill;

    always_comb begin
        misaligned = 1'b0;
        be_next    = BE_WORD;
        wdata_next = mem_wdata;
        case (mem_op)
            OP_BU, OP_B: begin
                be_next    = BE_BYTE << mem_addr[1:0];
                wdata_next = {4{mem_wdata[7:0]}};
            end
            OP_HU, OP_H: begin
                misaligned = mem_addr[0];
                be_next    = BE_HALF << {mem_addr[1], 1'b0};
                wdata_next = {2{mem_wdata[15:0]}};
            end
            default: misaligned = |mem_addr[1:0];
        endcase
    end

    assign req_go = (state == ST_IDLE) && mem_valid && !flush;
    assign accept = req_go && !misaligned;
    assign stall  = !reset && ((state == ST_REQ) || accept);
    // A flush arriving on the ack/timeout cycle itself must also squash the result.
    assign kill   = flushed || flush;

    load_extend u_load_extend (
        .addr_lo (lat_lo),
        .op      (lat_op),
        .word    (bus_rdata),
        .ext     (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            flushed     <= 1'b0;
            lat_op      <= OP_W;
            lat_lo      <= 2'b00;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            exc_adel    <= 1'b0;
            exc_ades    <= 1'b0;
            bus_err     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_be      <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            exc_adel    <= 1'b0;
            exc_ades    <= 1'b0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    flushed <= 1'b0;
                    cnt     <= '0;
                    if (req_go && misaligned) begin
                        exc_adel <= !mem_we;
                        exc_ades <= mem_we;
                    end else if (accept) begin
                        lat_op    <= mem_op;
                        lat_lo    <= mem_addr[1:0];
                        bus_we    <= mem_we;
                        bus_be    <= be_next;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_wdata <= wdata_next;
                        bus_req   <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush) flushed <= 1'b1;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= ST_DONE;
                        if (!bus_we && !kill) begin
                            rdata       <= ext_data;
                            rdata_valid <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus_req <= 1'b0;
                        bus_err <= !kill;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl.
module tb_dm_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_we, flush;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, rdata_valid, exc_adel, exc_ades, bus_err;
    logic        bus_req, bus_we, bus_ack;
    logic [3:0]  bus_be;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    // Per-access observations filled in by run_access.
    int          o_stall, o_req, o_rv, o_rv_cyc, o_err, o_err_cyc, o_adel, o_ades;
    logic        o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;

    always #5 clk = ~clk;

    dm_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one MEM instruction and watch it for a fixed window. mem_valid is
    // held while the pipeline is stalled, like a real MEM stage. ack comes on
    // REQ cycle index ack_dly (0 = first); flush pulses on cycle flush_at.
    task automatic run_access(input logic we, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_dly, input logic [31:0] rd,
                              input int flush_at);
        logic last_stall;
        o_stall = 0; o_req = 0; o_rv = 0; o_rv_cyc = -1; o_err = 0;
        o_err_cyc = -1; o_adel = 0; o_ades = 0;
        o_we = 1'b0; o_be = '0; o_addr = '0; o_wdata = '0; o_rdata = rdata;
        mem_valid = 1'b1; mem_we = we; mem_op = op; mem_addr = addr;
        mem_wdata = wd; bus_ack = 1'b0; flush = (flush_at == 0);
        #1;
        last_stall = stall;
        if (stall) o_stall++;
        for (int c = 1; c <= TIMEOUT + 6; c++) begin
            @(posedge clk); #1;
            if (rdata_valid) begin o_rv++; o_rv_cyc = c; o_rdata = rdata; end
            if (bus_err) begin o_err++; o_err_cyc = c; end
            if (exc_adel) o_adel++;
            if (exc_ades) o_ades++;
            if (!last_stall) mem_valid = 1'b0;
            flush = (c == flush_at);
            bus_ack = 1'b0;
            if (bus_req) begin
                o_req++;
                o_we = bus_we; o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata;
                if (o_req - 1 == ack_dly) begin bus_ack = 1'b1; bus_rdata = rd; end
            end
            #1;
            last_stall = stall;
            if (stall) o_stall++;
        end
        mem_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_op = 3'b000;
        mem_addr = '0; mem_wdata = '0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_be_addr", {28'd0, bus_be} | bus_addr | bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_strobes", {27'd0, rdata_valid, exc_adel, exc_ades, bus_err, bus_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // lb from byte 3, ack on first REQ cycle
        run_access(1'b0, 3'b010, 32'h0000_1003, 32'h0, 0, 32'h80AA_BBCC, -1);
        check("lb_be", {28'd0, o_be}, 32'h8);
        check("lb_addr", o_addr, 32'h0000_1000);
        check("lb_rdata", o_rdata, 32'hFFFF_FF80);
        check("lb_rv_cnt", o_rv, 1);
        check("lb_rv_cycle", o_rv_cyc, 2);
        check("lb_stall", o_stall, 2);
        check("lb_req", o_req, 1);

        // sh to upper half
        run_access(1'b1, 3'b100, 32'h0000_2002, 32'h1234_5678, 0, 32'h0, -1);
        check("sh_we", {31'd0, o_we}, 32'd1);
        check("sh_be", {28'd0, o_be}, 32'hC);
        check("sh_wdata", o_wdata, 32'h5678_5678);
        check("sh_addr", o_addr, 32'h0000_2000);
        check("sh_rv", o_rv, 0);
        check("sh_stall", o_stall, 2);

        // sb replication and byte-1 enable
        run_access(1'b1, 3'b001, 32'h0000_2101, 32'h0000_00A5, 1, 32'h0, -1);
        check("sb_be", {28'd0, o_be}, 32'h2);
        check("sb_wdata", o_wdata, 32'hA5A5_A5A5);
        check("sb_stall", o_stall, 3);

        // misaligned accesses
        run_access(1'b0, 3'b000, 32'h0000_1002, 32'h0, 0, 32'h0, -1);
        check("lw_mis_adel", o_adel, 1);
        check("lw_mis_req", o_req, 0);
        check("lw_mis_stall", o_stall, 0);
        run_access(1'b0, 3'b011, 32'h0000_1001, 32'h0, 0, 32'h0, -1);
        check("lhu_mis_adel", o_adel, 1);
        check("lhu_mis_req", o_req, 0);
        run_access(1'b1, 3'b100, 32'h0000_2003, 32'h0, 0, 32'h0, -1);
        check("sh_mis_ades", o_ades, 1);
        check("sh_mis_adel", o_adel, 0);
        check("sh_mis_req", o_req, 0);

        // lhu with ack withheld: timeout
        run_access(1'b0, 3'b011, 32'h0000_5002, 32'h0, 1000, 32'h0, -1);
        check("to_be", {28'd0, o_be}, 32'hC);
        check("to_req_cycles", o_req, TIMEOUT);
        check("to_err_cnt", o_err, 1);
        check("to_err_cycle", o_err_cyc, TIMEOUT + 1);
        check("to_rv", o_rv, 0);
        check("to_stall", o_stall, TIMEOUT + 1);

        // lbu flushed in REQ, ack three cycles later: transfer completes silently
        run_access(1'b0, 3'b001, 32'h0000_0000, 32'h0, 3, 32'h0000_00FF, 1);
        check("fl_req", o_req, 4);
        check("fl_rv", o_rv, 0);
        check("fl_err", o_err, 0);
        check("fl_rdata_kept", rdata, 32'hFFFF_FF80);

        // following loads accepted normally
        run_access(1'b0, 3'b100, 32'h0000_3002, 32'h0, 0, 32'h8001_0000, -1);
        check("lh_rdata", o_rdata, 32'hFFFF_8001);
        check("lh_rv", o_rv, 1);
        run_access(1'b0, 3'b001, 32'h0000_1001, 32'h0, 2, 32'h80AA_BBCC, -1);
        check("lbu_rdata", o_rdata, 32'h0000_00BB);
        check("lbu_rv_cycle", o_rv_cyc, 4);
        run_access(1'b0, 3'b000, 32'h0000_4000, 32'h0, 0, 32'hDEAD_BEEF, -1);
        check("lw_be", {28'd0, o_be}, 32'hF);
        check("lw_rdata", o_rdata, 32'hDEAD_BEEF);
        run_access(1'b0, 3'b011, 32'h0000_4000, 32'h0, 0, 32'h1234_8765, -1);
        check("lhu_rdata", o_rdata, 32'h0000_8765);

        // reset during REQ abandons the transfer
        mem_valid = 1'b1; mem_we = 1'b0; mem_op = 3'b001; mem_addr = 32'h0000_6000;
        @(posedge clk); #1;
        check("rr_req_before", {31'd0, bus_req}, 32'd1);
        reset = 1'b1; mem_valid = 1'b0;
        @(posedge clk); #1;
        check("rr_req_after", {31'd0, bus_req}, 32'd0);
        check("rr_bus_zero", {28'd0, bus_be} | bus_addr | bus_wdata, 32'd0);
        check("rr_rdata_zero", rdata, 32'd0);
        check("rr_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0000_00FF;
        #1;
        check("rr_stall_idle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("rr_late_ack", {29'd0, rdata_valid, bus_req, bus_err}, 32'd0);
        check("rr_late_rdata", rdata, 32'd0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
